// File: rtl/fetch_unit_if.sv
// Fetch front-end bundle: instruction-memory port, redirect input and decode handshake.
// master = fetch_unit, slave = memory/execute/decode side.
interface fetch_unit_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]               imem_addr;
    logic [31:0]                    imem_rdata;
    logic                           imem_valid;
    logic                           redirect;
    logic [WIDTH-1:0]               redirect_pc;
    logic                           out_valid;
    logic                           out_ready;
    logic [31:0]                    out_instr;
    logic [WIDTH-1:0]               out_pc;
    logic [$clog2(DEPTH+1)-1:0]     fifo_count;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, fifo_count,
        input  imem_rdata, imem_valid, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, fifo_count,
        output imem_rdata, imem_valid, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, buffers {pc, instr} in a DEPTH-entry prefetch FIFO.
// Latency 1 cycle (0 with FETCH_BYPASS_EN, which forwards imem_rdata straight to decode when empty).
// Backpressure: full FIFO without a pop stalls fetch and holds imem_addr; redirect flushes everything.
module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [31:0]      instr;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [WIDTH-1:0] fpc;
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             byp;
    logic             fifo_pop;
    logic             consume;
    logic             push;
    logic             advance;

    assign head  = mem[rptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    assign bus.imem_addr  = fpc;
    assign bus.fifo_count = count;

`ifdef FETCH_BYPASS_EN
    // Empty FIFO: present the word coming back from memory in the same cycle.
    assign byp           = empty && bus.imem_valid && !bus.redirect;
    assign bus.out_instr = byp ? bus.imem_rdata : head.instr;
    assign bus.out_pc    = byp ? fpc : head.pc;
`else
    assign byp           = 1'b0;
    assign bus.out_instr = head.instr;
    assign bus.out_pc    = head.pc;
`endif

    assign bus.out_valid = (!empty || byp) && !bus.redirect;
    assign fifo_pop      = !empty && bus.out_ready && !bus.redirect;
    assign consume       = byp && bus.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push          = bus.imem_valid && !bus.redirect && (!full || fifo_pop) && !consume;
    assign advance       = push || consume;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fpc   <= RESET_PC;
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.redirect) begin
            fpc   <= {bus.redirect_pc[WIDTH-1:2], 2'b00};
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= {fpc, bus.imem_rdata};
                wptr      <= wptr + 1'b1;
            end
            if (advance) begin
                fpc <= fpc + WIDTH'(4);
            end
            if (fifo_pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !fifo_pop) begin
                count <= count + 1'b1;
            end else if (fifo_pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, backpressure, redirect, wait states, wrap, bypass.
module tb_fetch_unit;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    fetch_unit_if #(.WIDTH(32), .DEPTH(4)) bus  ();
    fetch_unit_if #(.WIDTH(32), .DEPTH(4)) wbus ();

    // Memory model: each word is the bitwise inverse of its address.
    assign bus.imem_rdata  = ~bus.imem_addr;
    assign wbus.imem_rdata = ~wbus.imem_addr;

    fetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    fetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst), .bus(wbus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b0;
        bus.imem_valid  = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready   = 1'b0;
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst              = 1'b0;
        bus.redirect     = 1'b1;
        bus.redirect_pc  = 32'h0000_0200;
        bus.imem_valid   = 1'b1;
        bus.out_ready    = 1'b0;
        wbus.imem_valid  = 1'b0;
        wbus.redirect    = 1'b0;
        wbus.redirect_pc = '0;
        wbus.out_ready   = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (bus.imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_addr: got %h expected %h", bus.imem_addr, 32'h0);
        end
        n_checks++;
        if (bus.fifo_count !== 3'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.fifo_count);
        end
        bus.redirect   = 1'b0;
        bus.imem_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid);
        end
        n_checks++;
        if (bus.out_instr !== 32'h0 || bus.out_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_out: got instr %h pc %h expected 0 0", bus.out_instr, bus.out_pc);
        end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        do_reset();
        bus.imem_valid = 1'b1;
        bus.out_ready  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.fifo_count !== 3'((k == 0) ? 0 : LAT)) begin
                n_fail++; $display("FAIL stream_count[%0d]: got %0d expected %0d", k, bus.fifo_count, (k == 0) ? 0 : LAT);
            end
            if (k < LAT) begin
                n_checks++;
                if (bus.out_valid !== 1'b0) begin
                    n_fail++; $display("FAIL stream_valid[%0d]: got %b expected 0", k, bus.out_valid);
                end
            end else begin
                e = 32'(4 * (k - LAT));
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_pc !== e || bus.out_instr !== ~e) begin
                    n_fail++; $display("FAIL stream_out[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                                       k, bus.out_valid, bus.out_pc, bus.out_instr, e, ~e);
                end
            end
            next_cycle();
        end
        // Reset in the middle of streaming restarts from RESET_PC.
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.fifo_count !== 3'd0 || bus.imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL midreset: got count=%0d addr=%h expected 0 0", bus.fifo_count, bus.imem_addr);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.imem_valid = 1'b1;
        bus.out_ready  = 1'b0;
        repeat (6) next_cycle();
        @(negedge clk);
        n_checks++;
        if (bus.fifo_count !== 3'd4 || bus.imem_addr !== 32'h10) begin
            n_fail++; $display("FAIL bp_full: got count=%0d addr=%h expected 4 00000010", bus.fifo_count, bus.imem_addr);
        end
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin
            n_fail++; $display("FAIL bp_head: got v=%b pc=%h expected 1 0", bus.out_valid, bus.out_pc);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (bus.out_pc !== 32'h0 || bus.out_instr !== 32'hFFFF_FFFF || bus.imem_addr !== 32'h10) begin
            n_fail++; $display("FAIL bp_stable: got pc=%h instr=%h addr=%h expected 0 ffffffff 10",
                               bus.out_pc, bus.out_instr, bus.imem_addr);
        end
        bus.out_ready = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * k) || bus.fifo_count !== 3'd4) begin
                n_fail++; $display("FAIL bp_drain[%0d]: got v=%b pc=%h count=%0d expected 1 %h 4",
                                   k, bus.out_valid, bus.out_pc, bus.fifo_count, 32'(4 * k));
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_redirect_full();
        logic [31:0] e;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        bus.out_ready   = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL redir_valid: got %b expected 0", bus.out_valid);
        end
        next_cycle();
        bus.redirect   = 1'b0;
        bus.imem_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.fifo_count !== 3'd0 || bus.imem_addr !== 32'h100) begin
            n_fail++; $display("FAIL redir_flush: got count=%0d addr=%h expected 0 00000100", bus.fifo_count, bus.imem_addr);
        end
        for (int k = 0; k < 3; k++) begin
            if (k < LAT) begin
                n_checks++;
                if (bus.out_valid !== 1'b0) begin
                    n_fail++; $display("FAIL redir_bubble[%0d]: got %b expected 0", k, bus.out_valid);
                end
            end else begin
                e = 32'h100 + 32'(4 * (k - LAT));
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_pc !== e || bus.out_instr !== ~e) begin
                    n_fail++; $display("FAIL redir_out[%0d]: got v=%b pc=%h instr=%h expected 1 %h %h",
                                       k, bus.out_valid, bus.out_pc, bus.out_instr, e, ~e);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wait_states();
        bit          ivp  [6];
        bit          vexp [6];
        logic [31:0] pexp [6];
        ivp = '{1, 0, 0, 1, 0, 0};
`ifdef FETCH_BYPASS_EN
        vexp = '{1, 0, 0, 1, 0, 0};
        pexp = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h0};
`else
        vexp = '{0, 1, 0, 0, 1, 0};
        pexp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0};
`endif
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.imem_valid = ivp[k];
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== vexp[k] || (vexp[k] && bus.out_pc !== pexp[k])) begin
                n_fail++; $display("FAIL wait[%0d]: got v=%b pc=%h expected v=%b pc=%h",
                                   k, bus.out_valid, bus.out_pc, vexp[k], pexp[k]);
            end
            if (k == 2) begin
                n_checks++;
                if (bus.imem_addr !== 32'h4) begin
                    n_fail++; $display("FAIL wait_hold: got addr=%h expected 00000004", bus.imem_addr);
                end
            end
            next_cycle();
        end
        bus.imem_valid = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        do_reset();
        wbus.imem_valid = 1'b1;
        wbus.out_ready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k >= LAT) begin
                e = 32'hFFFF_FFF8 + 32'(4 * (k - LAT));
                n_checks++;
                if (wbus.out_valid !== 1'b1 || wbus.out_pc !== e || wbus.out_instr !== ~e) begin
                    n_fail++; $display("FAIL wrap_pc[%0d]: got v=%b pc=%h instr=%h expected 1 %h %h",
                                       k, wbus.out_valid, wbus.out_pc, wbus.out_instr, e, ~e);
                end
            end
            next_cycle();
        end
        wbus.imem_valid = 1'b0;
        wbus.out_ready  = 1'b0;
    endtask

    task automatic test_ptr_wrap();
        logic [31:0] e;
        int          hs;
        e  = 32'h0;
        hs = 0;
        do_reset();
        bus.imem_valid = 1'b1;
        for (int k = 0; k < 28; k++) begin
            bus.out_ready = (k % 2 == 1);
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (bus.out_pc !== e || bus.out_instr !== ~e) begin
                    n_fail++; $display("FAIL ptr_order[%0d]: got pc=%h instr=%h expected %h %h",
                                       k, bus.out_pc, bus.out_instr, e, ~e);
                end
                e  = e + 32'd4;
                hs = hs + 1;
            end
            next_cycle();
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (hs != 14) begin
            n_fail++; $display("FAIL ptr_handshakes: got %0d expected 14", hs);
        end
        n_checks++;
        if (bus.fifo_count !== 3'd4 || bus.imem_addr !== 32'h48 || bus.out_pc !== 32'h38) begin
            n_fail++; $display("FAIL ptr_final: got count=%0d addr=%h pc=%h expected 4 00000048 00000038",
                               bus.fifo_count, bus.imem_addr, bus.out_pc);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        bus.imem_valid = 1'b1;
        bus.out_ready  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== (LAT == 0) || bus.fifo_count !== 3'd0) begin
            n_fail++; $display("FAIL byp_first: got v=%b count=%0d expected v=%b count=0",
                               bus.out_valid, bus.fifo_count, (LAT == 0));
        end
        if (LAT == 0) begin
            n_checks++;
            if (bus.out_instr !== bus.imem_rdata || bus.out_instr !== 32'hFFFF_FFFF) begin
                n_fail++; $display("FAIL byp_instr: got %h expected ffffffff", bus.out_instr);
            end
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (bus.fifo_count !== 3'(LAT) || bus.out_pc !== 32'(4 * (1 - LAT))) begin
            n_fail++; $display("FAIL byp_second: got count=%0d pc=%h expected %0d %h",
                               bus.fifo_count, bus.out_pc, LAT, 32'(4 * (1 - LAT)));
        end
        bus.imem_valid = 1'b0;
        bus.out_ready  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_wait_states();
        test_wrap();
        test_ptr_wrap();
        test_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
